// File: rtl/caesar_cipher_pipe_if.sv
// Character stream handshake between the cipher pipeline and its source and sink.
// The source/sink side uses master; the cipher uses slave.
interface caesar_cipher_pipe_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_mode;
    logic [7:0] in_char;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       out_nonalpha;

    modport master (
        output in_valid, in_mode, in_char, out_ready,
        input  in_ready, out_valid, out_char, out_nonalpha
    );

    modport slave (
        input  in_valid, in_mode, in_char, out_ready,
        output in_ready, out_valid, out_char, out_nonalpha
    );
endinterface

// File: rtl/caesar_cipher_pipe.sv
// Pipelined multi-key Caesar cipher: NUM_KEYS shift stages, one key per stage,
// valid/ready handshake with whole-pipe stall and a validated runtime key load.
module caesar_cipher_pipe #(
    parameter int NUM_KEYS      = 2,
    parameter bit PASS_NONALPHA = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_load,
    input  logic [5*NUM_KEYS-1:0] key_vec,
    input  logic                  key_dir,
    caesar_cipher_pipe_if.slave   bus,
    output logic                  err_key,
    output logic                  err_char,
    output logic                  busy,
    output logic [CNT_W-1:0]      char_count
);

    typedef struct packed {
        logic       valid;
        logic [7:0] ch;
        logic       mode;
        logic       letter;
        logic       upper;   // case base: 1 = 0x41, 0 = 0x61
    } stage_t;

    stage_t     st  [NUM_KEYS];
    stage_t     nxt [NUM_KEYS];
    stage_t     in_stage;
    logic [4:0] keys [NUM_KEYS];
    logic       kdir;
    logic       stall;
    logic       accept;
    logic       in_upper;
    logic       in_lower;
    logic       keys_ok;
    logic       load_ok;

    // 7-bit offset arithmetic keeps the wrap inside 0..25 without 8-bit overflow.
    function automatic stage_t apply_key(input stage_t s, input logic [4:0] k, input logic dir);
        stage_t     r;
        logic [6:0] base;
        logic [6:0] off;
        logic [6:0] t;
        r    = s;
        base = s.upper ? 7'h41 : 7'h61;
        off  = s.ch[6:0] - base;
        if (s.mode ^ dir) begin
            t = off - {2'b00, k};
            if (t[6]) t = t + 7'd26;
        end else begin
            t = off + {2'b00, k};
            if (t >= 7'd26) t = t - 7'd26;
        end
        if (s.letter) r.ch = {1'b0, base + t};
        return r;
    endfunction

    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign accept       = bus.in_valid && !stall;

    assign bus.out_valid    = st[NUM_KEYS-1].valid;
    assign bus.out_char     = st[NUM_KEYS-1].ch;
    assign bus.out_nonalpha = st[NUM_KEYS-1].valid && !st[NUM_KEYS-1].letter;

    assign in_upper = (bus.in_char >= 8'h41) && (bus.in_char <= 8'h5A);
    assign in_lower = (bus.in_char >= 8'h61) && (bus.in_char <= 8'h7A);
    assign err_char = accept && !(in_upper || in_lower) && !PASS_NONALPHA;
    assign load_ok  = key_load && !busy && !accept;

    always_comb begin
        in_stage        = '0;
        in_stage.ch     = bus.in_char;
        in_stage.mode   = bus.in_mode;
        in_stage.letter = in_upper || in_lower;
        in_stage.upper  = in_upper;
        in_stage.valid  = accept && (in_upper || in_lower || PASS_NONALPHA);
        nxt[0] = apply_key(in_stage, keys[0], kdir);
        for (int unsigned i = 1; i < NUM_KEYS; i++)
            nxt[i] = apply_key(st[i-1], keys[i], kdir);
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++)
            busy = busy | st[i].valid;
    end

    always_comb begin
        keys_ok = 1'b1;
        for (int unsigned i = 0; i < NUM_KEYS; i++)
            if (key_vec[5*i +: 5] > 5'd26) keys_ok = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) st[i] <= '0;
        end else if (!stall) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) st[i] <= nxt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) keys[i] <= '0;
            kdir    <= 1'b0;
            err_key <= 1'b0;
        end else if (key_load) begin
            if (load_ok && keys_ok) begin
                for (int unsigned i = 0; i < NUM_KEYS; i++) keys[i] <= key_vec[5*i +: 5];
                kdir    <= key_dir;
                err_key <= 1'b0;
            end else begin
                err_key <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            char_count <= '0;
        else if (bus.out_valid && bus.out_ready && char_count != '1)
            char_count <= char_count + 1'b1;
    end

endmodule

// File: tb/tb_caesar_cipher_pipe.sv
// Scoreboard bench for caesar_cipher_pipe: a pass-through instance carries the
// main traffic, a drop-mode instance covers discarded non-letters.
module tb_caesar_cipher_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_load;
    logic [9:0]  key_vec;
    logic        key_dir;
    logic        err_key1, err_char1, busy1;
    logic [15:0] cnt1;
    logic        key_load2;
    logic [9:0]  key_vec2;
    logic        key_dir2;
    logic        err_key2, err_char2, busy2;
    logic [15:0] cnt2;

    int checks = 0;
    int errors = 0;
    int cur_k0 = 0, cur_k1 = 0;
    logic cur_dir = 1'b0;
    logic [8:0] sb [$];

    caesar_cipher_pipe_if bus1 ();
    caesar_cipher_pipe_if bus2 ();

    caesar_cipher_pipe #(.NUM_KEYS(2), .PASS_NONALPHA(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_vec(key_vec), .key_dir(key_dir),
        .bus(bus1), .err_key(err_key1), .err_char(err_char1), .busy(busy1), .char_count(cnt1)
    );

    caesar_cipher_pipe #(.NUM_KEYS(2), .PASS_NONALPHA(1'b0), .CNT_W(16)) dut_drop (
        .clk(clk), .rst_n(rst_n), .key_load(key_load2), .key_vec(key_vec2), .key_dir(key_dir2),
        .bus(bus2), .err_key(err_key2), .err_char(err_char2), .busy(busy2), .char_count(cnt2)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] c, input logic m);
        int b, o;
        if (c >= 8'h41 && c <= 8'h5A) b = 65;
        else if (c >= 8'h61 && c <= 8'h7A) b = 97;
        else return c;
        o = int'(c) - b;
        o = ((m ^ cur_dir) ? (o + 26 - cur_k0) : (o + cur_k0)) % 26;
        o = ((m ^ cur_dir) ? (o + 26 - cur_k1) : (o + cur_k1)) % 26;
        return 8'(b + o);
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A);
    endfunction

    // Output monitor: every handshake on the pass-through instance is checked in order.
    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            logic [8:0] exp;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got char=%h nonalpha=%b, required no output",
                         bus1.out_char, bus1.out_nonalpha);
            end else begin
                exp = sb.pop_front();
                if ({bus1.out_nonalpha, bus1.out_char} !== exp) begin
                    errors++;
                    $display("FAIL out_char: got nonalpha=%b char=%h, required nonalpha=%b char=%h",
                             bus1.out_nonalpha, bus1.out_char, exp[8], exp[7:0]);
                end
            end
        end
    end

    task automatic send_char(input logic [7:0] c, input logic m);
        int n = 0;
        bus1.in_valid = 1'b1;
        bus1.in_char  = c;
        bus1.in_mode  = m;
        @(negedge clk);
        while (!bus1.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus1.in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", bus1.in_ready);
            @(posedge clk);
        end else begin
            @(posedge clk);
            sb.push_back({!is_letter(c), model(c, m)});
        end
        #1 bus1.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0 || busy1) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d busy=%b, required 0/0", sb.size(), busy1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys(input logic [4:0] k0, input logic [4:0] k1, input logic d);
        key_vec  = {k1, k0};
        key_dir  = d;
        key_load = 1'b1;
        @(posedge clk);
        #1 key_load = 1'b0;
        if (k0 <= 5'd26 && k1 <= 5'd26) begin
            cur_k0  = int'(k0);
            cur_k1  = int'(k1);
            cur_dir = d;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus1.out_valid, bus1.in_ready, busy1, err_key1, bus1.out_nonalpha} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_flags: got ov/ir/busy/ek/na=%b, required 01000",
                     {bus1.out_valid, bus1.in_ready, busy1, err_key1, bus1.out_nonalpha});
        end
        checks++;
        if (cnt1 !== 16'd0 || bus1.out_char !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got count=%0d char=%h, required 0 and 00", cnt1, bus1.out_char);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        load_keys(5'd3, 5'd5, 1'b0);
        send_char(8'h41, 1'b0);
        send_char(8'h7A, 1'b0);
        drain();
        checks++;
        if (cnt1 !== 16'd2) begin
            errors++;
            $display("FAIL basic_count: got %0d, required 2", cnt1);
        end
    endtask

    task automatic test_latency();
        send_char(8'h43, 1'b0);
        @(negedge clk);
        checks++;
        if (bus1.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%b one cycle after accept, required 0", bus1.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus1.out_valid !== 1'b1 || bus1.out_char !== 8'h4B) begin
            errors++;
            $display("FAIL latency_out: got valid=%b char=%h, required 1 and 4b", bus1.out_valid, bus1.out_char);
        end
        drain();
    endtask

    task automatic test_decrypt();
        send_char(8'h49, 1'b1);
        send_char(8'h68, 1'b1);
        drain();
        load_keys(5'd3, 5'd5, 1'b1);
        send_char(8'h61, 1'b0);
        drain();
    endtask

    task automatic test_identity();
        load_keys(5'd26, 5'd0, 1'b0);
        send_char(8'h4D, 1'b0);
        drain();
        load_keys(5'd27, 5'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (err_key1 !== 1'b1) begin
            errors++;
            $display("FAIL bad_key_err: got err_key=%b, required 1", err_key1);
        end
        @(posedge clk);
        #1;
        send_char(8'h41, 1'b0);
        drain();
        load_keys(5'd3, 5'd5, 1'b0);
        @(negedge clk);
        checks++;
        if (err_key1 !== 1'b0) begin
            errors++;
            $display("FAIL good_key_clear: got err_key=%b, required 0", err_key1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_nonalpha();
        int pulses = 0;
        int outs = 0;
        send_char(8'h21, 1'b0);
        drain();
        bus2.in_valid = 1'b1;
        bus2.in_char  = 8'h21;
        @(negedge clk);
        checks++;
        if (err_char2 !== 1'b1 || bus2.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drop_accept: got err_char=%b in_ready=%b, required 1/1", err_char2, bus2.in_ready);
        end
        @(posedge clk);
        #1 bus2.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (err_char2) pulses++;
            if (bus2.out_valid || busy2) outs++;
        end
        checks++;
        if (pulses != 0 || outs != 0 || cnt2 !== 16'd0) begin
            errors++;
            $display("FAIL drop_after: got extra_pulses=%0d outputs=%0d count=%0d, required 0/0/0",
                     pulses, outs, cnt2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [6];
        logic [15:0] base_cnt;
        msg = '{8'h48, 8'h65, 8'h6C, 8'h4C, 8'h6F, 8'h57};
        base_cnt = cnt1;
        fork
            begin
                for (int i = 0; i < 6; i++) send_char(msg[i], 1'b0);
            end
            begin
                logic [7:0] held;
                repeat (3) @(posedge clk);
                #1 bus1.out_ready = 1'b0;
                @(negedge clk);
                held = bus1.out_char;
                checks++;
                if (bus1.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_valid: got out_valid=%b, required 1", bus1.out_valid);
                end
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk);
                    checks++;
                    if (bus1.in_ready !== 1'b0 || bus1.out_char !== held) begin
                        errors++;
                        $display("FAIL stall_hold: got in_ready=%b char=%h, required 0 and %h",
                                 bus1.in_ready, bus1.out_char, held);
                    end
                end
                @(posedge clk);
                #1 bus1.out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (cnt1 !== base_cnt + 16'd6) begin
            errors++;
            $display("FAIL stream_count: got %0d, required %0d", cnt1, base_cnt + 16'd6);
        end
    endtask

    task automatic test_reset_midflight();
        bus1.out_ready = 1'b0;
        send_char(8'h41, 1'b0);
        send_char(8'h42, 1'b0);
        load_keys(5'd1, 5'd1, 1'b0);
        cur_k0 = 3;
        cur_k1 = 5;
        @(negedge clk);
        checks++;
        if (err_key1 !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL busy_load: got err_key=%b busy=%b, required 1/1", err_key1, busy1);
        end
        #1;
        sb.delete();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus1.out_valid !== 1'b0 || busy1 !== 1'b0 || cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL midflight_reset: got ov=%b busy=%b count=%0d, required 0/0/0",
                     bus1.out_valid, busy1, cnt1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus1.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_out: got out_valid=%b, required 0", bus1.out_valid);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        key_load       = 1'b0;
        key_vec        = '0;
        key_dir        = 1'b0;
        key_load2      = 1'b0;
        key_vec2       = '0;
        key_dir2       = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_char   = '0;
        bus1.in_mode   = 1'b0;
        bus1.out_ready = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_char   = '0;
        bus2.in_mode   = 1'b0;
        bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        test_reset();
        test_basic();
        test_latency();
        test_decrypt();
        test_identity();
        test_nonalpha();
        test_back_to_back();
        test_reset_midflight();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
